// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter that shares one multi-cycle ALU among NREQ requesters.
// It accepts one operation at a time, holds the operands for LAT cycles, then pulses the result back.
module alu_req_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32,
  parameter int OPW   = 3,
  parameter int LAT   = 2
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [NREQ-1:0]       ReqValid,
  output logic [NREQ-1:0]       ReqReady,
  input  logic [NREQ*WIDTH-1:0] ReqArgA,
  input  logic [NREQ*WIDTH-1:0] ReqArgB,
  input  logic [NREQ*OPW-1:0]   ReqOp,
  output logic [WIDTH-1:0]      AluArgA,
  output logic [WIDTH-1:0]      AluArgB,
  output logic [OPW-1:0]        AluOp,
  output logic                  AluIssue,
  input  logic [WIDTH-1:0]      AluResult,
  output logic [NREQ-1:0]       RspValid,
  output logic [WIDTH-1:0]      RspResult,
  output logic [2:0]            RspId,
  output logic                  Busy
);

  localparam int CW = $clog2(LAT + 1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           r_state;
  logic [2:0]       r_lastGnt;
  logic [2:0]       r_gnt;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_aluArgA;
  logic [WIDTH-1:0] r_aluArgB;
  logic [OPW-1:0]   r_aluOp;
  logic             r_aluIssue;
  logic [NREQ-1:0]  r_rspValid;
  logic [WIDTH-1:0] r_rspResult;
  logic [2:0]       r_rspId;

  logic [NREQ-1:0]  w_sel;
  logic             w_found;
  int               w_gntIdx;
  logic [NREQ-1:0]  w_gntOneHot;

  // Scan starting just after the last winner so every requester gets a turn within NREQ grants.
  always_comb begin
    w_sel    = '0;
    w_found  = 1'b0;
    w_gntIdx = 0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!w_found && ReqValid[(int'(r_lastGnt) + k) % NREQ]) begin
        w_found  = 1'b1;
        w_gntIdx = (int'(r_lastGnt) + k) % NREQ;
        w_sel[(int'(r_lastGnt) + k) % NREQ] = 1'b1;
      end
    end
  end

  assign w_gntOneHot = {{(NREQ-1){1'b0}}, 1'b1} << r_gnt;
  assign ReqReady    = (r_state == IDLE && !Rst) ? w_sel : '0;
  assign Busy        = (r_state != IDLE);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state     <= IDLE;
      r_lastGnt   <= 3'(NREQ - 1);
      r_gnt       <= '0;
      r_cnt       <= '0;
      r_aluArgA   <= '0;
      r_aluArgB   <= '0;
      r_aluOp     <= '0;
      r_aluIssue  <= 1'b0;
      r_rspValid  <= '0;
      r_rspResult <= '0;
      r_rspId     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_rspValid <= '0;
          r_aluIssue <= 1'b0;
          if (w_found) begin
            r_aluArgA  <= ReqArgA[w_gntIdx*WIDTH +: WIDTH];
            r_aluArgB  <= ReqArgB[w_gntIdx*WIDTH +: WIDTH];
            r_aluOp    <= ReqOp[w_gntIdx*OPW +: OPW];
            r_lastGnt  <= 3'(w_gntIdx);
            r_gnt      <= 3'(w_gntIdx);
            r_cnt      <= CW'(LAT);
            r_aluIssue <= 1'b1;
            r_state    <= EXEC;
          end
        end
        EXEC: begin
          r_aluIssue <= 1'b0;
          r_cnt      <= r_cnt - CW'(1);
          // Last cycle of stable operands: the ALU output is valid now.
          if (r_cnt == CW'(1)) begin
            r_rspResult <= AluResult;
            r_rspId     <= r_gnt;
            r_rspValid  <= w_gntOneHot;
            r_state     <= RESP;
          end
        end
        RESP: begin
          r_rspValid <= '0;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign AluArgA   = r_aluArgA;
  assign AluArgB   = r_aluArgB;
  assign AluOp     = r_aluOp;
  assign AluIssue  = r_aluIssue;
  assign RspValid  = r_rspValid;
  assign RspResult = r_rspResult;
  assign RspId     = r_rspId;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Scoreboard bench for alu_req_arbiter with an adder standing in for the ALU.
module tb_alu_req_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 32;
  localparam int OPW   = 3;
  localparam int LAT   = 2;

  logic                  Clk = 1'b0;
  logic                  Rst;
  logic [NREQ-1:0]       ReqValid;
  logic [NREQ-1:0]       ReqReady;
  logic [NREQ*WIDTH-1:0] ReqArgA;
  logic [NREQ*WIDTH-1:0] ReqArgB;
  logic [NREQ*OPW-1:0]   ReqOp;
  logic [WIDTH-1:0]      AluArgA;
  logic [WIDTH-1:0]      AluArgB;
  logic [OPW-1:0]        AluOp;
  logic                  AluIssue;
  logic [WIDTH-1:0]      AluResult;
  logic [NREQ-1:0]       RspValid;
  logic [WIDTH-1:0]      RspResult;
  logic [2:0]            RspId;
  logic                  Busy;

  alu_req_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .OPW(OPW), .LAT(LAT)) dut (
    .Clk(Clk), .Rst(Rst), .ReqValid(ReqValid), .ReqReady(ReqReady),
    .ReqArgA(ReqArgA), .ReqArgB(ReqArgB), .ReqOp(ReqOp),
    .AluArgA(AluArgA), .AluArgB(AluArgB), .AluOp(AluOp), .AluIssue(AluIssue),
    .AluResult(AluResult), .RspValid(RspValid), .RspResult(RspResult),
    .RspId(RspId), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  assign AluResult = AluArgA + AluArgB;

  typedef struct {
    int               id;
    logic [WIDTH-1:0] res;
    int               cyc;
  } exp_t;

  exp_t             sbQ[$];
  int               grantQ[$];
  int               grantCyc[$];
  int               nVectors     = 0;
  int               nMiscompares = 0;
  int               cycle        = 0;
  int               rspCount     = 0;
  logic             issuePending = 1'b0;
  logic [WIDTH-1:0] expA;
  logic [WIDTH-1:0] expB;
  logic [OPW-1:0]   expOp;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    nVectors++;
    if (observed !== expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Monitor: pushes expected results on each transfer, pops and checks on each response.
  always @(negedge Clk) begin
    cycle++;
    if (Rst) begin
      sbQ.delete();
      issuePending = 1'b0;
    end else begin
      if (issuePending || AluIssue) begin
        checkOutput("alu_issue", AluIssue, issuePending);
        if (issuePending) begin
          checkOutput("alu_arg_a", AluArgA, expA);
          checkOutput("alu_arg_b", AluArgB, expB);
          checkOutput("alu_op", AluOp, expOp);
        end
      end
      issuePending = 1'b0;
      if (|(ReqValid & ReqReady)) begin
        int   g;
        exp_t e;
        g = 0;
        checkOutput("ready_onehot", $countones(ReqReady), 1);
        for (int i = 0; i < NREQ; i++)
          if (ReqValid[i] && ReqReady[i]) g = i;
        expA  = ReqArgA[g*WIDTH +: WIDTH];
        expB  = ReqArgB[g*WIDTH +: WIDTH];
        expOp = ReqOp[g*OPW +: OPW];
        e.id  = g;
        e.res = expA + expB;
        e.cyc = cycle;
        sbQ.push_back(e);
        grantQ.push_back(g);
        grantCyc.push_back(cycle);
        issuePending = 1'b1;
      end
      if (|RspValid) begin
        if (sbQ.size() == 0) begin
          checkOutput("spurious_rsp", RspValid, 0);
        end else begin
          exp_t e;
          e = sbQ.pop_front();
          checkOutput("rsp_valid", RspValid, 64'(1) << e.id);
          checkOutput("rsp_id", RspId, e.id);
          checkOutput("rsp_result", RspResult, e.res);
          checkOutput("rsp_latency", cycle - e.cyc, LAT + 1);
          rspCount++;
        end
      end
    end
  end

  task automatic applyStimulus(input int idx, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic [OPW-1:0] op);
    ReqArgA[idx*WIDTH +: WIDTH] = a;
    ReqArgB[idx*WIDTH +: WIDTH] = b;
    ReqOp[idx*OPW +: OPW]       = op;
    ReqValid[idx]               = 1'b1;
  endtask

  task automatic waitGrants(input int n);
    int t = 0;
    while (grantQ.size() < n && t < 100) begin
      @(negedge Clk); #1;
      t++;
    end
    if (grantQ.size() < n) checkOutput("timeout_grant", grantQ.size(), n);
  endtask

  task automatic waitRsp(input int target);
    int t = 0;
    while (rspCount < target && t < 100) begin
      @(negedge Clk); #1;
      t++;
    end
    if (rspCount < target) checkOutput("timeout_rsp", rspCount, target);
  endtask

  task automatic runSingle(input int idx, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [OPW-1:0] op);
    int n0;
    int r0;
    @(posedge Clk); #1;
    n0 = grantQ.size();
    r0 = rspCount;
    applyStimulus(idx, a, b, op);
    waitGrants(n0 + 1);
    @(posedge Clk); #1;
    ReqValid[idx] = 1'b0;
    waitRsp(r0 + 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int expOrder[6] = '{0, 1, 2, 3, 0, 1};
    int r0;

    Rst      = 1'b1;
    ReqValid = '1;
    for (int i = 0; i < NREQ; i++) begin
      ReqArgA[i*WIDTH +: WIDTH] = 32'h11111111 * (i + 1);
      ReqArgB[i*WIDTH +: WIDTH] = 32'h00000100 * (i + 1);
      ReqOp[i*OPW +: OPW]       = OPW'(i);
    end

    repeat (2) begin
      @(negedge Clk);
      checkOutput("rst_ready", ReqReady, 0);
      checkOutput("rst_busy", Busy, 0);
      checkOutput("rst_alu_a", AluArgA, 0);
      checkOutput("rst_alu_b", AluArgB, 0);
      checkOutput("rst_alu_op", AluOp, 0);
      checkOutput("rst_issue", AluIssue, 0);
      checkOutput("rst_rsp_valid", RspValid, 0);
      checkOutput("rst_rsp_result", RspResult, 0);
      checkOutput("rst_rsp_id", RspId, 0);
    end

    grantQ.delete();
    grantCyc.delete();
    @(posedge Clk); #1;
    Rst = 1'b0;
    waitGrants(6);
    @(posedge Clk); #1;
    ReqValid = '0;
    waitRsp(6);
    if (grantQ.size() >= 6) begin
      for (int i = 0; i < 6; i++) checkOutput("fair_order", grantQ[i], expOrder[i]);
      for (int i = 0; i < 5; i++) checkOutput("fair_spacing", grantCyc[i+1] - grantCyc[i], LAT + 2);
    end

    runSingle(0, 32'h01234567, 32'h89abcdef, 3'd5);
    checkOutput("single_result", RspResult, 32'h8ACF1356);
    checkOutput("single_id", RspId, 0);

    runSingle(1, 32'h00000010, 32'h00000020, 3'd1);
    @(posedge Clk); #1;
    grantQ.delete();
    r0 = rspCount;
    applyStimulus(1, 32'h00000aaa, 32'h00000111, 3'd2);
    applyStimulus(3, 32'h00000bbb, 32'h00000222, 3'd3);
    waitGrants(3);
    @(posedge Clk); #1;
    ReqValid = '0;
    waitRsp(r0 + 3);
    if (grantQ.size() >= 3) begin
      checkOutput("sparse_g0", grantQ[0], 3);
      checkOutput("sparse_g1", grantQ[1], 1);
      checkOutput("sparse_g2", grantQ[2], 3);
    end

    runSingle(2, 32'h80000000, 32'h80000000, 3'd0);
    checkOutput("wrap_min", RspResult, 32'h00000000);
    runSingle(3, 32'h7fffffff, 32'h7fffffff, 3'd7);
    checkOutput("wrap_max", RspResult, 32'hFFFFFFFE);

    @(posedge Clk); #1;
    grantQ.delete();
    applyStimulus(2, 32'hdead0000, 32'h0000beef, 3'd4);
    waitGrants(1);
    @(posedge Clk); #1;
    ReqValid[2] = 1'b0;
    @(posedge Clk); #1;
    Rst = 1'b1;
    @(posedge Clk); #1;
    Rst = 1'b0;
    r0 = rspCount;
    @(negedge Clk); #1;
    checkOutput("busy_after_rst", Busy, 0);
    @(posedge Clk); #1;
    grantQ.delete();
    applyStimulus(0, 32'h00001000, 32'h00000001, 3'd1);
    applyStimulus(2, 32'h00002000, 32'h00000002, 3'd2);
    waitGrants(2);
    @(posedge Clk); #1;
    ReqValid = '0;
    waitRsp(r0 + 2);
    if (grantQ.size() >= 2) begin
      checkOutput("post_rst_g0", grantQ[0], 0);
      checkOutput("post_rst_g1", grantQ[1], 2);
    end
    repeat (6) @(negedge Clk);
    #1;
    checkOutput("post_rst_rsp_count", rspCount, r0 + 2);
    checkOutput("sb_empty", sbQ.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
